// File: rtl/claa_pkg.sv
// Shared constants for the 4-bit carry-lookahead adder slice.
package claa_pkg;

  localparam int CLA_WIDTH = 4;

  // Cleared output word: carry-out in the top bit, sum below it.
  function automatic logic [CLA_WIDTH:0] reset_result();
    return '0;
  endfunction

endpackage

// File: rtl/cla_logic4.sv
// Purely combinational 4-bit carry-lookahead core: every carry is a flat
// sum of products over generate/propagate terms, so no carry waits on another.
module cla_logic4
  import claa_pkg::*;
(
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [CLA_WIDTH-1:0] sum,
  output logic                 cout
);

  logic [CLA_WIDTH-1:0] g;
  logic [CLA_WIDTH-1:0] p;
  logic [CLA_WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[CLA_WIDTH-1:0];
  assign cout = c[CLA_WIDTH];

endmodule

// File: rtl/claa_adder4.sv
// 4-bit carry-lookahead adder with scalar bit ports and a one-cycle
// output register; reset clears the registered sum and carry.
module claa_adder4
  import claa_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic Cin,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic Cout
);

  logic [CLA_WIDTH-1:0] a;
  logic [CLA_WIDTH-1:0] b;
  logic [CLA_WIDTH-1:0] sum;
  logic                 cout;
  logic [CLA_WIDTH:0]   result_q;

  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};

  cla_logic4 u_cla_logic4 (
    .a    (a),
    .b    (b),
    .cin  (Cin),
    .sum  (sum),
    .cout (cout)
  );

  // Reset wins over a same-edge add; otherwise capture one result per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= reset_result();
    end else begin
      result_q <= {cout, sum};
    end
  end

  assign S0   = result_q[0];
  assign S1   = result_q[1];
  assign S2   = result_q[2];
  assign S3   = result_q[3];
  assign Cout = result_q[4];

endmodule

// File: tb/tb_claa_adder4.sv
// Directed and exhaustive self-checking bench for claa_adder4.
module tb_claa_adder4;

  logic clk = 1'b0;
  logic rst;
  logic A0, A1, A2, A3;
  logic B0, B1, B2, B3;
  logic Cin;
  logic S0, S1, S2, S3, Cout;

  int checks   = 0;
  int failures = 0;

  claa_adder4 dut (
    .clk  (clk),
    .rst  (rst),
    .A0   (A0),
    .A1   (A1),
    .A2   (A2),
    .A3   (A3),
    .B0   (B0),
    .B1   (B1),
    .B2   (B2),
    .B3   (B3),
    .Cin  (Cin),
    .S0   (S0),
    .S1   (S1),
    .S2   (S2),
    .S3   (S3),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic cin, input logic reset);
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
    Cin = cin;
    rst = reset;
  endtask

  // Compares {Cout, S3..S0} against a bench-computed value.
  task automatic checkOutput(input string tag, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {Cout, S3, S2, S1, S0};
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] prev_exp;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ec;

    applyStimulus(4'b0110, 4'b0111, 1'b1, 1'b1);
    stepClock();
    checkOutput("reset_cycle1", 5'b00000);
    applyStimulus(4'b1001, 4'b1101, 1'b0, 1'b1);
    stepClock();
    checkOutput("reset_cycle2", 5'b00000);

    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    stepClock();
    checkOutput("release_zero", 5'b00000);

    applyStimulus(4'b1010, 4'b0000, 1'b0, 1'b0);
    stepClock();
    checkOutput("a1010_plus_0", 5'b01010);

    // Back-to-back: after each new vector is driven, the previous result must still be held.
    applyStimulus(4'b1011, 4'b1110, 1'b0, 1'b0);
    #1 checkOutput("b2b_hold_prev", 5'b01010);
    stepClock();
    checkOutput("b2b_11_14", 5'b11001);
    applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
    #1 checkOutput("b2b_hold_25", 5'b11001);
    stepClock();
    checkOutput("b2b_15_15", 5'b11110);
    applyStimulus(4'b1110, 4'b1011, 1'b0, 1'b0);
    #1 checkOutput("b2b_hold_30", 5'b11110);
    stepClock();
    checkOutput("b2b_14_11", 5'b11001);
    applyStimulus(4'b1111, 4'b1100, 1'b0, 1'b0);
    #1 checkOutput("b2b_hold_25b", 5'b11001);
    stepClock();
    checkOutput("b2b_15_12", 5'b11011);

    applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
    stepClock();
    checkOutput("cin_prop_15_0_1", 5'b10000);
    applyStimulus(4'b0101, 4'b1010, 1'b1, 1'b0);
    stepClock();
    checkOutput("cin_prop_5_10_1", 5'b10000);

    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1);
    stepClock();
    checkOutput("reset_midstream", 5'b00000);
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
    stepClock();
    checkOutput("max_after_reset", 5'b11111);

    // Exhaustive sweep: each result is checked one cycle later, while the next operands are already driven.
    prev_exp = 5'b00000;
    for (int i = 0; i < 512; i++) begin
      ea = i[3:0];
      eb = i[7:4];
      ec = i[8];
      applyStimulus(ea, eb, ec, 1'b0);
      #1;
      if (i > 0) checkOutput("exhaustive", prev_exp);
      prev_exp = 5'(ea) + 5'(eb) + 5'(ec);
      stepClock();
    end
    checkOutput("exhaustive_last", prev_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
